// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting NUM_REQ requesters access to a
// single memory bus, one access at a time.
//
// Ports
//   clock, reset        : clock (rising edge) and asynchronous active-low reset
//   req_valid/req_rwn   : per-requester request and direction (1 = read)
//   req_addr/req_wdata  : packed per-requester address / write data, slice i = requester i
//   req_ready           : one-hot accept pulse, high in the IDLE cycle of the grant
//   rsp_valid           : one-hot completion pulse for the requester that owned the bus
//   rsp_rdata           : read data of the last completed read
//   rsp_error           : completion was a watchdog abort (coincident with rsp_valid)
//   cs/rwn/addr/wdata   : registered memory bus outputs
//   rdy/rdata           : memory completion strobe and read data
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add an ACCESS watchdog that
// aborts an access after TIMEOUT_CYCLES clocks without rdy.

module mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 220,
    parameter int unsigned ADDR_WIDTH     = 210,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_rwn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_error,
    output logic                          cs,
    output logic                          rwn,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          rdy,
    input  logic [DATA_WIDTH-1:0]         rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]     NREQ       = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] HOT0       = {{(NUM_REQ-1){1'b0}}, 1'b1};

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("mem_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_grant;   // also identifies the current bus owner in ACCESS
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic [IDX_W:0]     probe;
    logic [NUM_REQ-1:0] ready_hot;
    logic               take;
    logic               finish;
    logic               abort;
    logic               timeout_hit;

    // Round-robin search starting at last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        probe       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            probe = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (probe >= NREQ) begin
                probe = probe - NREQ;
            end
            if (!grant_found && req_valid[probe[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // reset gates the grant so req_ready stays low while reset is held.
    always_comb begin
        state_next = state;
        ready_hot  = '0;
        take       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_found && reset) begin
                    take                 = 1'b1;
                    ready_hot[grant_idx] = 1'b1;
                    state_next           = ACCESS;
                end
            end
            ACCESS: begin
                // rdy wins over a watchdog expiry in the same cycle
                if (rdy) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = ready_hot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= LAST_INIT;
            cs         <= 1'b0;
            rwn        <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= '0;
            if (take) begin
                last_grant <= grant_idx;
                cs         <= 1'b1;
                rwn        <= req_rwn[grant_idx];
                addr       <= req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata      <= req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (finish || abort) begin
                cs        <= 1'b0;
                rsp_valid <= HOT0 << last_grant;
            end
            if (finish && rwn) begin
                rsp_rdata <= rdata;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // timer counts completed ACCESS clocks minus one; it reads TIMEOUT_CYCLES-1
    // during the last permitted ACCESS clock.
    localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;

    assign timeout_hit = (timer == LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer     <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_error <= abort;
            if (take) begin
                timer <= '0;
            end else if (state == ACCESS && !timeout_hit) begin
                timer <= timer + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_error   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes the
// expected grant / completion into queues; a negedge monitor pops and compares
// whenever req_ready or rsp_valid is seen. A small memory model answers with
// rdy after a programmable number of ACCESS clocks (0 = never).

module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NR = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_rwn = '1;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic              cs;
    logic              rwn;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              rdy;
    logic [DW-1:0]     rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .req_valid(req_valid),
        .req_rwn(req_rwn),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .cs(cs),
        .rwn(rwn),
        .addr(addr),
        .wdata(wdata),
        .rdy(rdy),
        .rdata(rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int            idx;
        logic          rwn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        logic [NR-1:0] hot;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];
    logic [DW-1:0] model_rdata = '0;

    // memory model
    int   lat = 0;
    int   acc = 0;
    logic auto_rdy = 1'b0;
    logic idle_rdy = 1'b0;
    logic [DW-1:0] rd_val = '0;
    assign rdy   = auto_rdy | idle_rdy;
    assign rdata = rd_val;

    initial forever begin
        @(posedge clk);
        #1;
        if (cs) acc++;
        else acc = 0;
        auto_rdy = cs && (lat != 0) && (acc == lat);
    end

    // monitor
    initial begin
        grant_t g;
        rsp_t   e;
        logic   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("bus_cs", cs, 1'b1);
                    chk("bus_rwn", rwn, g.rwn);
                    chk("bus_addr", addr, g.addr);
                    chk("bus_wdata", wdata, g.wdata);
                    pend = 1'b0;
                end
                if (req_ready != 0) begin
                    if (gq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL grant_unexpected actual=%b required=none", req_ready);
                    end else begin
                        g = gq.pop_front();
                        chk("grant", req_ready, 4'b0001 << g.idx);
                        pend = 1'b1;
                    end
                end
                if (rsp_valid != 0) begin
                    if (rq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
                    end else begin
                        e = rq.pop_front();
                        chk("rsp_valid", rsp_valid, e.hot);
                        chk("rsp_error", rsp_error, e.err);
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_cs", cs, 1'b0);
        chk("rst_rwn", rwn, 1'b1);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Queue expectations, raise the request, wait for its grant, then withdraw
    // and scramble its inputs so any leak onto the bus is visible.
    task automatic issue(input int r, input logic is_rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int latency,
                         input bit exp_rsp, input logic exp_err);
        grant_t g;
        rsp_t   e;
        int     n;
        g = '{idx: r, rwn: is_rd, addr: a, wdata: d};
        gq.push_back(g);
        if (exp_rsp) begin
            if (is_rd && !exp_err) model_rdata = rd_val;
            e = '{hot: 4'b0001 << r, rdata: model_rdata, err: exp_err};
            rq.push_back(e);
        end
        @(posedge clk);
        #1;
        lat = latency;
        req_rwn[r] = is_rd;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_valid[r] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 0 && n < 30);
        chk("grant_seen", req_ready != 0, 1'b1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        req_rwn[r] = ~is_rd;
        req_addr[r*AW +: AW] = ~a;
        req_wdata[r*DW +: DW] = ~d;
    endtask

    task automatic count_cs(input int exp_cs, input logic is_rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        int bad;
        n = 0;
        bad = 0;
        forever begin
            @(negedge clk);
            if (!cs || n >= 60) break;
            n++;
            if (rwn !== is_rd || addr !== a || wdata !== d) bad++;
        end
        chk("cs_cycles", n, exp_cs);
        chk("bus_hold", bad, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((gq.size() != 0 || rq.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", gq.size() + rq.size(), 0);
    endtask

    initial begin
        grant_t g;
        rsp_t   e;
        int     n;

        // reset state, with requests present while reset is held
        req_valid = '1;
        #12;
        check_reset_state();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single read from requester 0, rdy on the 3rd ACCESS clock
        rd_val = 32'h0000_00A5;
        issue(0, 1'b1, 16'h0010, 32'h0, 3, 1'b1, 1'b0);
        count_cs(3, 1'b1, 16'h0010, 32'h0);
        drain();
        chk("read_rdata", rsp_rdata, 32'h0000_00A5);

        // write from requester 2; rsp_rdata must keep 0xA5
        rd_val = 32'h0000_DEAD;
        issue(2, 1'b0, 16'h0022, 32'h0000_005A, 2, 1'b1, 1'b0);
        count_cs(2, 1'b0, 16'h0022, 32'h0000_005A);
        drain();
        chk("write_keeps_rdata", rsp_rdata, 32'h0000_00A5);

        // rdy while idle does nothing
        rd_val = 32'h0000_1234;
        @(posedge clk);
        #1;
        idle_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_rdy = 1'b0;
        @(negedge clk);
        chk("idle_rdy_cs", cs, 1'b0);
        chk("idle_rdy_rdata", rsp_rdata, 32'h0000_00A5);

        // all four requesting after reset: 0,1,2,3,0 at one grant per 2 clocks
        do_reset();
        lat = 1;
        rd_val = 32'h0000_C0DE;
        model_rdata = rd_val;
        for (int i = 0; i < 5; i++) begin
            g = '{idx: i % NR, rwn: 1'b1, addr: 16'(16'h0100 + (i % NR)),
                  wdata: 32'(32'h11 * (i % NR))};
            gq.push_back(g);
            e = '{hot: 4'b0001 << (i % NR), rdata: 32'h0000_C0DE, err: 1'b0};
            rq.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            req_rwn[i] = 1'b1;
            req_addr[i*AW +: AW] = 16'(16'h0100 + i);
            req_wdata[i*DW +: DW] = 32'(32'h11 * i);
        end
        req_valid = '1;
        repeat (9) @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // reset in the middle of an access: cs drops at once, no completion
        issue(2, 1'b1, 16'h02A2, 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // requester 0 wins first after release
        lat = 1;
        rd_val = 32'h0000_0077;
        model_rdata = rd_val;
        g = '{idx: 0, rwn: 1'b1, addr: 16'h0300, wdata: 32'h0};
        gq.push_back(g);
        e = '{hot: 4'b0001, rdata: 32'h0000_0077, err: 1'b0};
        rq.push_back(e);
        for (int i = 0; i < NR; i++) begin
            req_rwn[i] = 1'b1;
            req_addr[i*AW +: AW] = 16'(16'h0300 + i);
            req_wdata[i*DW +: DW] = '0;
        end
        req_valid = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 0 && n < 30);
        chk("post_reset_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

`ifdef MEM_ARB_TIMEOUT_EN
        // no rdy: abort after 8 ACCESS clocks with rsp_error
        rd_val = 32'h0000_5151;
        issue(1, 1'b1, 16'h0041, 32'h0, 0, 1'b1, 1'b1);
        count_cs(TO, 1'b1, 16'h0041, 32'h0);
        drain();
        chk("timeout_rdata", rsp_rdata, 32'h0000_0077);
        // rdy on the 8th clock completes normally
        rd_val = 32'h0000_BEEF;
        issue(3, 1'b1, 16'h0043, 32'h0, TO, 1'b1, 1'b0);
        count_cs(TO, 1'b1, 16'h0043, 32'h0);
        drain();
        chk("limit_rdy_rdata", rsp_rdata, 32'h0000_BEEF);
`else
        // without the watchdog an access waits as long as it takes
        rd_val = 32'h0000_5151;
        issue(1, 1'b1, 16'h0041, 32'h0, 0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("wait_cs", cs, 1'b1);
        chk("wait_rsp_valid", rsp_valid, 0);
        chk("wait_rsp_error", rsp_error, 1'b0);
        @(posedge clk);
        #1;
        idle_rdy = 1'b1;
        @(posedge clk);
        #1;
        idle_rdy = 1'b0;
        drain();
        chk("late_rdy_rdata", rsp_rdata, 32'h0000_5151);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 220, SHALL set the mem bus data width.
REQ-002 Parameter ADDR_WIDTH, default 210, SHALL set the mem bus address width.
REQ-003 Parameter NUM_REQ, default 4, range 2..8, SHALL set the number of requesters.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit in clocks (used only with MEM_ARB_TIMEOUT_EN).
REQ-005 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  SHALL carry the per-requester access request.
REQ-008 req_rwn  in  NUM_REQ  SHALL select read (1) or write (0) per requester.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH  SHALL carry the packed per-requester address; requester i in slice i.
REQ-010 req_wdata  in  NUM_REQ*DATA_WIDTH  SHALL carry the packed per-requester write data.
REQ-011 req_ready  out  NUM_REQ  SHALL be a one-cycle, one-hot accept pulse.
REQ-012 rsp_valid  out  NUM_REQ  SHALL be a one-cycle, one-hot completion pulse.
REQ-013 rsp_rdata  out  DATA_WIDTH  SHALL carry the read data of the last completed read.
REQ-014 rsp_error  out  1  SHALL flag a timed-out completion, coincident with rsp_valid.
REQ-015 cs, rwn  out  1 each  SHALL drive mem bus select and direction.
REQ-016 addr  out  ADDR_WIDTH and wdata  out  DATA_WIDTH  SHALL drive the mem bus address and write data.
REQ-017 rdy  in  1 and rdata  in  DATA_WIDTH  SHALL be the mem bus completion strobe and read data.

Function
REQ-018 FSM SHALL have two states: IDLE and ACCESS.
REQ-019 In IDLE with any req_valid high, the arbiter SHALL grant round-robin, searching from last_grant+1 modulo NUM_REQ, pulse req_ready[g], latch rwn/addr/wdata of g, and enter ACCESS at the next edge.
REQ-020 In ACCESS, cs SHALL be 1 and rwn/addr/wdata SHALL hold the latched values; all bus outputs SHALL be registered.
REQ-021 When rdy=1 is sampled in ACCESS, the next edge SHALL drop cs, pulse rsp_valid[g], load rsp_rdata from rdata if read (unchanged if write), and return to IDLE.
REQ-022 A new grant SHALL be issued in the same cycle rsp_valid pulses, giving a minimum of 2 clocks per access.
REQ-023 rdy while in IDLE SHALL be ignored.
REQ-024 last_grant SHALL update only on a grant; requesters not granted SHALL keep waiting with no starvation beyond NUM_REQ-1 grants.
REQ-025 Changes to req_* of the granted requester after its req_ready pulse SHALL NOT affect the bus.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, cs=0, rwn=1, addr=0, wdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, and last_grant=NUM_REQ-1.
REQ-027 Reset mid-ACCESS SHALL abandon the access with no rsp_valid pulse.

Configuration
REQ-028 With MEM_ARB_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL abort the access once TIMEOUT_CYCLES clocks elapse without rdy: cs drops, rsp_valid[g] and rsp_error pulse, rsp_rdata unchanged, and the FSM returns to IDLE.
REQ-029 rdy sampled in the same cycle as the counter limit SHALL complete normally, with rsp_error=0.
REQ-030 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist, rsp_error SHALL be tied 0, and ACCESS SHALL wait indefinitely.

Verification
REQ-031 Single read: req_valid=0001, addr 0x10, rdy after 3 ACCESS clocks with rdata=0xA5 -> req_ready=0001, cs high 3 clocks, rsp_valid=0001, rsp_rdata=0xA5.
REQ-032 All four requesting continuously after reset -> grant order 0,1,2,3,0; rdy every cycle gives one grant per 2 clocks.
REQ-033 Write from req 2 with wdata=0x5A -> rwn=0, wdata=0x5A during cs; rsp_valid=0100; rsp_rdata unchanged.
REQ-034 Reset asserted during ACCESS -> cs=0 immediately, no rsp_valid; after release, req 0 has first priority.
REQ-035 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, rdy never asserted -> cs drops after 8 ACCESS clocks, rsp_valid and rsp_error pulse together; rdy on clock 8 -> rsp_error=0.
